mat_result_stream: RTL
======================

Name: mat_result_stream

Overview:
- Downstream consumer of the 2-bit matrix add/sub path.
- Captures the 96-bit result matrix (16 elements × 6-bit fields) when the add path raises its finish level.
- Streams the 16 elements one per beat over a valid/ready interface, tagged with row/column indices, to the display/serial output stage.
- In subtract mode, converts each 3-bit two's-complement difference to a sign-extended 6-bit value.

Parameters:
- DIM, 4, matrix dimension; element count = DIM*DIM = 16, index width 4.
- ELEM_W, 6, field width per element in mat_in; mat_in width = DIM*DIM*ELEM_W = 96.
- RES_W, 3, significant result bits per field (adder output width).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mat_in  in  96  result matrix; element k occupies bits [95-6k : 90-6k] (k=0 at MSBs).
- mat_valid  in  1  upstream finish; level, stays high until upstream reset.
- sub_mode  in  1  1 = subtraction result (sign-extend), 0 = addition (pass field unchanged).
- out_data  out  6  current element value.
- out_row  out  2  k[3:2].
- out_col  out  2  k[1:0].
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_last  out  1  high with out_valid on k=15.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after last beat accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; k=0; capture register 0; mv_q (registered mat_valid) 0.
- Rising-edge detect: start = mat_valid & ~mv_q. If mat_valid is high on the first cycle after reset release, that counts as a rising edge.
- States:
  - IDLE: outputs 0. On start, capture mat_in and sub_mode, set k=0, go to STREAM.
  - STREAM: out_valid=1, busy=1; out_data/out_row/out_col/out_last are driven from the captured register and k. On out_valid&out_ready with k<15: k<=k+1. On transfer with k=15: go to DONE.
  - DONE: done=1, out_valid=0, busy=0 for exactly one cycle, then IDLE.
- Latency: start seen in cycle N → first beat (k=0) valid in cycle N+1. With out_ready held high, 16 beats in cycles N+1..N+16 and done in cycle N+17.
- Handshake: out_data, out_row, out_col and out_last stay stable while out_valid=1 and out_ready=0. out_valid never drops mid-stream. out_ready is ignored outside STREAM.
- Data rule: f = 6-bit field k.
  - sub_mode=0: out_data = f.
  - sub_mode=1: out_data = {3{f[2]}, f[2:0]}; f[5:3] is ignored.
- Capture isolation: mat_in and sub_mode changes after capture have no effect on the current stream.
- Retrigger: start edges during STREAM or DONE are ignored. A held-high mat_valid never restarts; it must go low for at least one cycle and rise again.
- Reset mid-operation: on the cycle after rst, outputs are 0, state is IDLE, no done pulse is produced, and the partial stream is discarded.
- out_last is asserted only when out_valid=1 and k=15.

Test Plan:
- Add mode, out_ready=1:
  - Stimulus: mat_in fields k=0..14 = 6'd5, k=15 = 6'd7; sub_mode=0; raise mat_valid in cycle N.
  - Required: 16 consecutive beats N+1..N+16, data 5, last beat data 7 with row=3, col=3, out_last=1; done pulse in N+17 only.
- Sub mode sign extension:
  - Stimulus: field0=6'b000111, field1=6'b000011, field2=6'b000100; sub_mode=1.
  - Required: out_data 6'h3F, 6'h03, 6'h3C. The same fields with sub_mode=0 give 6'h07, 6'h03, 6'h04.
- Backpressure: out_ready low for 4 cycles while k=2 is presented → out_data, row=0, col=2 held stable; the next accepted beat is k=3; exactly 16 transfers total.
- Level hold/retrigger:
  - mat_valid held high after done → out_valid stays 0 for 20 cycles.
  - Drop mat_valid 1 cycle, then raise it with new mat_in → new stream starts at k=0 with new data.
- Reset mid-stream: assert rst during the k=7 beat → next cycle out_valid=0, busy=0, done never pulses. A later rising edge restarts at k=0, row=0, col=0.
- Capture isolation: change mat_in and sub_mode every cycle during STREAM → emitted beats match the values captured at start.

Source files
------------

// File: rtl/mat_result_stream.sv
// Captures the add/sub result matrix on the rising edge of mat_valid and streams
// its elements one per beat, tagged with row/column, over a valid/ready interface.
module mat_result_stream #(
    parameter int DIM    = 4,
    parameter int ELEM_W = 6,
    parameter int RES_W  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIM*DIM*ELEM_W-1:0]   mat_in,
    input  logic                        mat_valid,
    input  logic                        sub_mode,
    output logic [ELEM_W-1:0]           out_data,
    output logic [$clog2(DIM)-1:0]      out_row,
    output logic [$clog2(DIM)-1:0]      out_col,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int NUM_ELEM = DIM * DIM;
    localparam int IDX_W    = $clog2(NUM_ELEM);
    localparam int COL_W    = $clog2(DIM);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   k, k_nxt;
    logic [ELEM_W-1:0]  cap [NUM_ELEM];
    logic               sub_q;
    logic               mv_q;
    logic               start;
    logic [ELEM_W-1:0]  field;
    logic [ELEM_W-1:0]  field_ext;

    // mv_q clears on reset, so a mat_valid already high at release reads as an edge.
    assign start = mat_valid & ~mv_q;

    // NOTE: the capture array is reset too, because the matrix must read back as zero
    // after reset; a pure data buffer would normally skip the reset and save the muxes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            sub_q <= 1'b0;
            mv_q  <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                cap[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            mv_q  <= mat_valid;
            if (state == IDLE && start) begin
                // Element 0 sits at the MSBs of mat_in.
                for (int i = 0; i < NUM_ELEM; i++) begin
                    cap[i] <= mat_in[(NUM_ELEM-1-i)*ELEM_W +: ELEM_W];
                end
                sub_q <= sub_mode;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case statement, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    k_nxt     = '0;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (k == K_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        k_nxt = k + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract results are 3-bit two's complement; the upper field bits are don't-care.
    assign field     = cap[k];
    assign field_ext = {{(ELEM_W-RES_W){field[RES_W-1]}}, field[RES_W-1:0]};

    assign out_data = out_valid ? (sub_q ? field_ext : field) : '0;
    assign out_row  = out_valid ? k[IDX_W-1:COL_W] : '0;
    assign out_col  = out_valid ? k[COL_W-1:0]     : '0;
    assign out_last = out_valid && (k == K_LAST);

endmodule
